rprelu_layer4: RTL and testbench

- Per-channel RPReLU activation stage placed directly downstream of the layer-4 BN/residual stage. It consumes that stage's `data_out` / `data_out_valid` vectors.
- Computes `y = f(x - gamma) + zeta`, where `f` is identity for non-negative inputs and a Q8 slope `beta` for negative inputs.
- Output is saturated to DATA_WIDTH and passed to the next binarisation/conv stage.
- Per-channel parameters are loaded word-serially by a small load FSM before data processing is enabled.

---
 rtl/rprelu_layer4_if.sv | 28 ++
 rtl/rprelu_layer4.sv | 148 ++++++++++++++
 tb/tb_rprelu_layer4.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rprelu_layer4_if.sv
// Handshake and data bundle between the layer-4 BN/residual stage, the
// parameter loader and the RPReLU activation block.
interface rprelu_layer4_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned PARA_WIDTH  = 16,
  parameter int unsigned CHANNEL_NUM = 128
);
  logic                           data_in_valid;
  logic                           mode_in;
  logic signed [DATA_WIDTH-1:0]   data_in [CHANNEL_NUM];
  logic                           para_load_start;
  logic                           para_in_valid;
  logic        [3*PARA_WIDTH-1:0] para_in;
  logic                           para_busy;
  logic                           para_ready;
  logic signed [DATA_WIDTH-1:0]   data_out [CHANNEL_NUM];
  logic                           data_out_valid;

  modport master (
    output data_in_valid, mode_in, data_in, para_load_start, para_in_valid, para_in,
    input  para_busy, para_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in_valid, mode_in, data_in, para_load_start, para_in_valid, para_in,
    output para_busy, para_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/rprelu_layer4.sv
// Per-channel RPReLU: y = sat(f(x - gamma) + zeta), f = identity or Q8 slope beta.
// Word-serial parameter loader plus a 2-stage, one-vector-per-cycle datapath.
module rprelu_layer4 #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned PARA_WIDTH  = 16,
  parameter int unsigned CHANNEL_NUM = 128
) (
  input logic           clk,
  input logic           rstn,
  rprelu_layer4_if.slave bus
);

  localparam int unsigned SW   = ((DATA_WIDTH > PARA_WIDTH) ? DATA_WIDTH : PARA_WIDTH) + 1;
  localparam int unsigned MW   = SW + PARA_WIDTH;
  localparam int unsigned TW   = MW + 1;
  localparam int unsigned FRAC = 8;
  localparam int unsigned CW   = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNEL_NUM - 1);
  localparam logic signed [DATA_WIDTH-1:0] DMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] DMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en;
  logic            para_busy_q, para_ready_q;
  logic            accept;

  logic signed [PARA_WIDTH-1:0] gamma_q [CHANNEL_NUM];
  logic signed [PARA_WIDTH-1:0] beta_q  [CHANNEL_NUM];
  logic signed [PARA_WIDTH-1:0] zeta_q  [CHANNEL_NUM];

  logic                         v1_q;
  logic signed [SW-1:0]         s_q     [CHANNEL_NUM];
  logic signed [PARA_WIDTH-1:0] beta1_q [CHANNEL_NUM];
  logic signed [PARA_WIDTH-1:0] zeta1_q [CHANNEL_NUM];

  logic signed [MW-1:0]         prod    [CHANNEL_NUM];
  logic signed [TW-1:0]         t       [CHANNEL_NUM];

  logic                         data_out_valid_q;
  logic signed [DATA_WIDTH-1:0] data_out_q [CHANNEL_NUM];

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [TW-1:0] v);
    if (v > TW'(DMAX))      return DMAX;
    else if (v < TW'(DMIN)) return DMIN;
    else                    return v[DATA_WIDTH-1:0];
  endfunction

  // Load FSM: a start pulse always wins over a coincident parameter word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    if (bus.para_load_start) begin
      state_d = LOAD;
      cnt_d   = '0;
    end else if (state_q == LOAD && bus.para_in_valid) begin
      wr_en = 1'b1;
      if (cnt_q == LAST_CH) begin
        state_d = READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      para_busy_q  <= 1'b0;
      para_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      para_busy_q  <= (state_d == LOAD);
      para_ready_q <= (state_d == READY);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        gamma_q[i] <= '0;
        beta_q[i]  <= '0;
        zeta_q[i]  <= '0;
      end
    end else if (wr_en) begin
      gamma_q[cnt_q] <= $signed(bus.para_in[3*PARA_WIDTH-1:2*PARA_WIDTH]);
      beta_q[cnt_q]  <= $signed(bus.para_in[2*PARA_WIDTH-1:PARA_WIDTH]);
      zeta_q[cnt_q]  <= $signed(bus.para_in[PARA_WIDTH-1:0]);
    end
  end

  assign accept = (state_q == READY) && bus.mode_in && bus.data_in_valid;

  // Stage 1: unsaturated offset; beta/zeta travel with the vector so a reload
  // cannot disturb data already in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q <= 1'b0;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        s_q[i]     <= '0;
        beta1_q[i] <= '0;
        zeta1_q[i] <= '0;
      end
    end else begin
      v1_q <= accept;
      if (accept) begin
        for (int i = 0; i < CHANNEL_NUM; i++) begin
          s_q[i]     <= SW'(bus.data_in[i]) - SW'(gamma_q[i]);
          beta1_q[i] <= beta_q[i];
          zeta1_q[i] <= zeta_q[i];
        end
      end
    end
  end

  // Stage 2 arithmetic: negative branch floors via arithmetic shift.
  always_comb begin
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      prod[i] = MW'(s_q[i]) * MW'(beta1_q[i]);
      if (s_q[i][SW-1]) t[i] = TW'(prod[i] >>> FRAC) + TW'(zeta1_q[i]);
      else              t[i] = TW'(s_q[i]) + TW'(zeta1_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out_valid_q <= 1'b0;
      for (int i = 0; i < CHANNEL_NUM; i++) data_out_q[i] <= '0;
    end else begin
      data_out_valid_q <= v1_q;
      if (v1_q) begin
        for (int i = 0; i < CHANNEL_NUM; i++) data_out_q[i] <= sat(t[i]);
      end
    end
  end

  assign bus.para_busy      = para_busy_q;
  assign bus.para_ready     = para_ready_q;
  assign bus.data_out_valid = data_out_valid_q;
  assign bus.data_out       = data_out_q;

endmodule

// File: tb/tb_rprelu_layer4.sv
// Scoreboard bench for rprelu_layer4: directed vectors push expectations,
// a negedge monitor pops and compares every output pulse.
module tb_rprelu_layer4;
  localparam int unsigned DW = 16;
  localparam int unsigned PW = 16;
  localparam int unsigned CH = 128;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rprelu_layer4_if #(.DATA_WIDTH(DW), .PARA_WIDTH(PW), .CHANNEL_NUM(CH)) bus ();
  rprelu_layer4 #(.DATA_WIDTH(DW), .PARA_WIDTH(PW), .CHANNEL_NUM(CH)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct packed {
    int                   cyc;
    logic [CH-1:0][DW-1:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ecnt   = 0;
  int   pg[CH], pb[CH], pz[CH];
  int   ng[CH], nb[CH], nz[CH];
  int   x[CH];
  int   hand[3];
  int   nhand = 0;
  logic [DW-1:0] last_out[CH];

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic int model(input int xv, input int g, input int b, input int z);
    int s, t;
    s = xv - g;
    if (s >= 0) t = s + z;
    else        t = ((s * b) >>> 8) + z;
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit valid, input bit mode, input bit acc);
    exp_t e;
    for (int c = 0; c < CH; c++) bus.data_in[c] = DW'(x[c]);
    bus.data_in_valid = valid;
    bus.mode_in       = mode;
    if (acc) begin
      e.cyc = ecnt + 2;
      for (int c = 0; c < CH; c++) e.v[c] = DW'(model(x[c], pg[c], pb[c], pz[c]));
      for (int i = 0; i < nhand; i++) e.v[i] = DW'(hand[i]);
      sb.push_back(e);
    end
    nhand = 0;
    tick();
    bus.data_in_valid = 1'b0;
    bus.mode_in       = 1'b0;
  endtask

  // Start pulse (optionally with a word that must be dropped), then nwords writes.
  task automatic load(input int nwords, input bit gaps, input bit junk);
    for (int c = 0; c < CH; c++) begin
      pg[c] = ng[c]; pb[c] = nb[c]; pz[c] = nz[c];
    end
    bus.para_load_start = 1'b1;
    bus.para_in_valid   = junk;
    bus.para_in         = {16'(777), 16'(3), 16'(99)};
    tick();
    bus.para_load_start = 1'b0;
    bus.para_in_valid   = 1'b0;
    chk("busy_after_start", int'(bus.para_busy), 1);
    chk("ready_after_start", int'(bus.para_ready), 0);
    for (int i = 0; i < nwords; i++) begin
      if (gaps && (i % 9 == 4)) begin
        bus.para_in_valid = 1'b0;
        bus.data_in_valid = 1'b1;
        bus.mode_in       = 1'b1;
        tick();
        bus.data_in_valid = 1'b0;
        bus.mode_in       = 1'b0;
        chk("busy_in_gap", int'(bus.para_busy), 1);
      end
      bus.para_in_valid = 1'b1;
      bus.para_in       = {16'(ng[i]), 16'(nb[i]), 16'(nz[i])};
      tick();
    end
    bus.para_in_valid = 1'b0;
    if (nwords == CH) begin
      chk("ready_after_load", int'(bus.para_ready), 1);
      chk("busy_after_load", int'(bus.para_busy), 0);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard at the right cycle.
  always @(negedge clk) begin
    if (!rstn) begin
      for (int c = 0; c < CH; c++) last_out[c] = '0;
    end else if (bus.data_out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid at cycle %0d expected none", ecnt);
      end else begin
        exp_t e;
        int   bad, first;
        logic [DW-1:0] a;
        e     = sb.pop_front();
        bad   = 0;
        first = -1;
        chk("latency", ecnt, e.cyc);
        for (int c = 0; c < CH; c++) begin
          a = bus.data_out[c];
          if (a !== e.v[c]) begin
            bad++;
            if (first < 0) first = c;
          end
        end
        checks++;
        if (bad != 0) begin
          errors++;
          a = bus.data_out[first];
          $display("FAIL vector_data: ch%0d got %0d expected %0d (%0d bad channels)",
                   first, $signed(a), $signed(e.v[first]), bad);
        end
      end
      for (int c = 0; c < CH; c++) last_out[c] = bus.data_out[c];
    end else begin
      int bad;
      logic [DW-1:0] a;
      bad = 0;
      for (int c = 0; c < CH; c++) begin
        a = bus.data_out[c];
        if (a !== last_out[c]) bad++;
      end
      chk("output_hold_bad_channels", bad, 0);
    end
  end

  initial begin
    rstn                = 1'b0;
    bus.data_in_valid   = 1'b0;
    bus.mode_in         = 1'b0;
    bus.para_load_start = 1'b0;
    bus.para_in_valid   = 1'b0;
    bus.para_in         = '0;
    for (int c = 0; c < CH; c++) begin
      bus.data_in[c] = '0;
      pg[c] = 0; pb[c] = 0; pz[c] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    tick();
    chk("reset_busy", int'(bus.para_busy), 0);
    chk("reset_ready", int'(bus.para_ready), 0);
    chk("reset_valid", int'(bus.data_out_valid), 0);
    chk("reset_out0", int'(bus.data_out[0]), 0);

    // Data before any load is dropped.
    for (int c = 0; c < CH; c++) x[c] = 100;
    send(1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    chk("noload_ready", int'(bus.para_ready), 0);
    chk("noload_out0", int'(bus.data_out[0]), 0);

    // Uniform parameters, basic identity / slope channels.
    for (int c = 0; c < CH; c++) begin
      ng[c] = 10; nb[c] = 64; nz[c] = 5;
    end
    load(CH, 1'b0, 1'b0);
    for (int c = 0; c < CH; c++) x[c] = c * 3 - 200;
    x[0] = 30; x[1] = -6; x[2] = 10;
    hand[0] = 25; hand[1] = 1; hand[2] = 5; nhand = 3;
    send(1'b1, 1'b1, 1'b1);
    repeat (3) tick();

    // Saturation and floor corners, gapped load.
    for (int c = 0; c < CH; c++) begin
      ng[c] = c * 37 - 2000; nb[c] = c * 5 - 300; nz[c] = c - 60;
    end
    ng[0] = -1000; nb[0] = 256; nz[0] = 0;
    ng[1] = 1000;  nb[1] = 256; nz[1] = 0;
    ng[2] = 0;     nb[2] = 1;   nz[2] = 0;
    load(CH, 1'b1, 1'b0);
    for (int c = 0; c < CH; c++) x[c] = c * 250 - 16000;
    x[0] = 32767; x[1] = -32768; x[2] = -3;
    hand[0] = 32767; hand[1] = -32768; hand[2] = -1; nhand = 3;
    send(1'b1, 1'b1, 1'b1);
    repeat (3) tick();

    // Back-to-back with mode_in low on the third cycle.
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < CH; c++) x[c] = i * 1000 + c * 7 - 500;
      x[0] = 100 * i;
      hand[0] = 1000 + 100 * i; nhand = 1;
      send(1'b1, i != 2, i != 2);
    end
    repeat (3) tick();

    // Reload while two vectors are in flight; coincident word must be dropped.
    for (int c = 0; c < CH; c++) x[c] = c * 11 - 700;
    x[0] = -200; hand[0] = 800; nhand = 1;
    send(1'b1, 1'b1, 1'b1);
    x[0] = 50; hand[0] = 1050; nhand = 1;
    send(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < CH; c++) begin
      ng[c] = c - 50; nb[c] = 300 - c * 4; nz[c] = 20 - c;
    end
    ng[0] = 0; nb[0] = 128; nz[0] = 3;
    load(CH, 1'b1, 1'b1);
    for (int c = 0; c < CH; c++) x[c] = 400 - c * 9;
    x[0] = -7; hand[0] = -1; nhand = 1;
    send(1'b1, 1'b1, 1'b1);
    repeat (3) tick();

    // Reset in the middle of a load.
    for (int c = 0; c < CH; c++) begin
      ng[c] = 5; nb[c] = 200; nz[c] = -2;
    end
    load(37, 1'b0, 1'b0);
    rstn = 1'b0;
    #2;
    chk("midreset_busy", int'(bus.para_busy), 0);
    chk("midreset_ready", int'(bus.para_ready), 0);
    chk("midreset_out0", int'(bus.data_out[0]), 0);
    for (int c = 0; c < CH; c++) begin
      pg[c] = 0; pb[c] = 0; pz[c] = 0;
    end
    tick();
    rstn = 1'b1;
    tick();
    bus.para_in_valid = 1'b1;
    bus.para_in       = {16'(5), 16'(200), 16'(-2)};
    repeat (CH + 2) tick();
    bus.para_in_valid = 1'b0;
    chk("nostart_busy", int'(bus.para_busy), 0);
    chk("nostart_ready", int'(bus.para_ready), 0);
    send(1'b1, 1'b1, 1'b0);
    repeat (3) tick();

    load(CH, 1'b0, 1'b0);
    for (int c = 0; c < CH; c++) x[c] = c * 13 - 800;
    x[0] = -5; hand[0] = -10; nhand = 1;
    send(1'b1, 1'b1, 1'b1);
    repeat (4) tick();

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
